// File: rtl/fetch_unit.sv
// IF-stage program counter and fetch controller: drives imem, holds one decoded-slot
// entry behind a valid/ready handshake, handles redirects and flags misaligned targets.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_FETCH | slot empty; next edge captures imem_data at pc into the slot
// S_VALID | slot holds an instruction waiting for decode to accept it
// S_FAULT | misaligned redirect seen; everything frozen until reset
module fetch_unit #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int              CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  output logic [XLEN-1:0]  imem_addr,
  input  logic [31:0]      imem_data,
  output logic [31:0]      id_instr,
  output logic [XLEN-1:0]  id_pc,
  output logic             id_valid,
  input  logic             id_ready,
  input  logic             redirect_valid,
  input  logic [XLEN-1:0]  redirect_target,
  output logic             fetch_fault,
  output logic [XLEN-1:0]  fault_pc,
  output logic [CNT_W-1:0] fetch_count
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {S_FETCH, S_VALID, S_FAULT} state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [31:0]       id_instr_q, id_instr_d;
  logic [XLEN-1:0]   id_pc_q, id_pc_d;
  logic              id_valid_q, id_valid_d;
  logic              fault_q, fault_d;
  logic [XLEN-1:0]   fault_pc_q, fault_pc_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              misaligned;

  assign misaligned = |redirect_target[1:0];

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    id_instr_d = id_instr_q;
    id_pc_d    = id_pc_q;
    id_valid_d = id_valid_q;
    fault_d    = fault_q;
    fault_pc_d = fault_pc_q;
    count_d    = count_q;
    case (state_q)
      S_FETCH, S_VALID: begin
        // redirect always wins over both fetch and handshake
        if (redirect_valid) begin
          id_valid_d = 1'b0;
          if (misaligned) begin
            state_d    = S_FAULT;
            fault_d    = 1'b1;
            fault_pc_d = redirect_target;
          end else begin
            state_d = S_FETCH;
            pc_d    = redirect_target;
          end
        end else if (state_q == S_FETCH) begin
          state_d    = S_VALID;
          id_instr_d = imem_data;
          id_pc_d    = pc_q;
          id_valid_d = 1'b1;
        end else if (id_ready) begin
          state_d    = S_FETCH;
          pc_d       = pc_q + XLEN'(4);
          id_valid_d = 1'b0;
          count_d    = count_q + CNT_W'(1);
        end
      end
      S_FAULT: begin
        id_valid_d = 1'b0;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_FETCH;
      pc_q       <= RESET_VECTOR;
      id_instr_q <= NOP;
      id_pc_q    <= '0;
      id_valid_q <= 1'b0;
      fault_q    <= 1'b0;
      fault_pc_q <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      id_instr_q <= id_instr_d;
      id_pc_q    <= id_pc_d;
      id_valid_q <= id_valid_d;
      fault_q    <= fault_d;
      fault_pc_q <= fault_pc_d;
      count_q    <= count_d;
    end
  end

  assign imem_addr   = pc_q;
  assign id_instr    = id_instr_q;
  assign id_pc       = id_pc_q;
  assign id_valid    = id_valid_q;
  assign fetch_fault = fault_q;
  assign fault_pc    = fault_pc_q;
  assign fetch_count = count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a spec-level model checked every cycle plus
// hand-computed literal expectations, and a second instance with a top-of-memory reset vector.
module tb_fetch_unit;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1, id_ready = 1'b0, redirect_valid = 1'b0;
  logic [31:0] redirect_target = '0;
  logic [31:0] imem_addr, imem_data, id_instr, id_pc, fault_pc, fetch_count;
  logic        id_valid, fetch_fault;

  logic        rst2 = 1'b1, id_ready2 = 1'b0;
  logic [31:0] imem_addr2, imem_data2, id_instr2, id_pc2, fault_pc2, fetch_count2;
  logic        id_valid2, fetch_fault2;

  logic [31:0] mem [0:255];
  int checks = 0, failures = 0;

  function automatic logic [31:0] imem_f(input logic [31:0] a);
    if (a[31:10] == '0) return mem[a[9:2]];
    return ~a;
  endfunction

  assign imem_data  = imem_f(imem_addr);
  assign imem_data2 = imem_f(imem_addr2);

  fetch_unit dut (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_data(imem_data),
    .id_instr(id_instr), .id_pc(id_pc), .id_valid(id_valid), .id_ready(id_ready),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .fetch_fault(fetch_fault), .fault_pc(fault_pc), .fetch_count(fetch_count)
  );

  fetch_unit #(.RESET_VECTOR(32'hFFFF_FFFC)) dut2 (
    .clk(clk), .rst(rst2), .imem_addr(imem_addr2), .imem_data(imem_data2),
    .id_instr(id_instr2), .id_pc(id_pc2), .id_valid(id_valid2), .id_ready(id_ready2),
    .redirect_valid(1'b0), .redirect_target(32'h0),
    .fetch_fault(fetch_fault2), .fault_pc(fault_pc2), .fetch_count(fetch_count2)
  );

  // Behavioural model: slot occupancy, pc, and a sticky fault flag.
  logic [31:0] m_pc = 0, m_instr = 32'h13, m_idpc = 0, m_fault_pc = 0, m_count = 0;
  logic        m_valid = 0, m_fault = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_pc = 0; m_instr = 32'h13; m_idpc = 0; m_fault_pc = 0; m_count = 0;
      m_valid = 0; m_fault = 0;
    end else if (m_fault) begin
      m_valid = 0;
    end else if (redirect_valid && redirect_target[1:0] != 2'b00) begin
      m_fault = 1; m_fault_pc = redirect_target; m_valid = 0;
    end else if (redirect_valid) begin
      m_pc = redirect_target; m_valid = 0;
    end else if (!m_valid) begin
      m_instr = imem_f(m_pc); m_idpc = m_pc; m_valid = 1;
    end else if (id_ready) begin
      m_pc = m_pc + 4; m_valid = 0; m_count = m_count + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("m_imem_addr",   imem_addr, m_pc);
    chk("m_id_valid",    {31'b0, id_valid}, {31'b0, m_valid});
    chk("m_id_instr",    id_instr, m_instr);
    chk("m_id_pc",       id_pc, m_idpc);
    chk("m_fetch_fault", {31'b0, fetch_fault}, {31'b0, m_fault});
    chk("m_fault_pc",    fault_pc, m_fault_pc);
    chk("m_fetch_count", fetch_count, m_count);
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h1000_0000 + 32'(i * 4);
    mem[0] = 32'hfff00093; mem[1] = 32'h00400113; mem[2] = 32'h00112223;

    step(2);
    chk("rst_valid", {31'b0, id_valid}, 32'd0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_instr", id_instr, 32'h00000013);
    chk("rst_count", fetch_count, 32'd0);

    // 1: streaming with id_ready held high
    rst = 0; id_ready = 1;
    step(1); chk("t1_v0", {31'b0, id_valid}, 32'd1); chk("t1_pc0", id_pc, 32'h0);
             chk("t1_i0", id_instr, 32'hfff00093);
    step(1); chk("t1_gap", {31'b0, id_valid}, 32'd0); chk("t1_addr4", imem_addr, 32'h4);
    step(1); chk("t1_pc1", id_pc, 32'h4); chk("t1_i1", id_instr, 32'h00400113);
    step(2); chk("t1_pc2", id_pc, 32'h8); chk("t1_i2", id_instr, 32'h00112223);
    step(1); chk("t1_count", fetch_count, 32'd3);
    id_ready = 0;

    // 2: back-pressure holds the slot
    rst = 1; step(1); rst = 0;
    step(1); chk("t2_v", {31'b0, id_valid}, 32'd1);
    step(5);
    chk("t2_hold_v", {31'b0, id_valid}, 32'd1); chk("t2_hold_pc", id_pc, 32'h0);
    chk("t2_hold_i", id_instr, 32'hfff00093); chk("t2_addr", imem_addr, 32'h0);
    chk("t2_cnt", fetch_count, 32'd0);
    id_ready = 1; step(1); chk("t2_addr4", imem_addr, 32'h4);
    id_ready = 0;

    // 3: redirect beats handshake in VALID
    step(1); chk("t3_v", {31'b0, id_valid}, 32'd1);
    redirect_valid = 1; redirect_target = 32'h40; id_ready = 1;
    step(1); redirect_valid = 0;
    chk("t3_squash", {31'b0, id_valid}, 32'd0); chk("t3_addr", imem_addr, 32'h40);
    chk("t3_cnt", fetch_count, 32'd1);
    step(1); chk("t3_pc", id_pc, 32'h40); chk("t3_v2", {31'b0, id_valid}, 32'd1);
    id_ready = 0;

    // 4: misaligned redirect freezes the unit
    redirect_valid = 1; redirect_target = 32'h42;
    step(1);
    chk("t4_fault", {31'b0, fetch_fault}, 32'd1); chk("t4_fpc", fault_pc, 32'h42);
    chk("t4_v", {31'b0, id_valid}, 32'd0);
    redirect_target = 32'h80;
    for (int i = 0; i < 4; i++) begin id_ready = ~id_ready; step(1); end
    redirect_valid = 0;
    chk("t4_addr", imem_addr, 32'h40); chk("t4_fpc2", fault_pc, 32'h42);
    chk("t4_cnt", fetch_count, 32'd1);

    // 5: reset out of FAULT and out of VALID
    rst = 1; step(1); rst = 0;
    chk("t5_fault", {31'b0, fetch_fault}, 32'd0); chk("t5_addr", imem_addr, 32'h0);
    chk("t5_cnt", fetch_count, 32'd0); chk("t5_instr", id_instr, 32'h00000013);
    step(1); chk("t5_v", {31'b0, id_valid}, 32'd1);
    rst = 1; step(1); rst = 0;
    chk("t5_v0", {31'b0, id_valid}, 32'd0); chk("t5_instr2", id_instr, 32'h00000013);

    // aligned redirect from FETCH, misaligned redirect from FETCH
    redirect_valid = 1; redirect_target = 32'h20; step(1);
    chk("fr_addr", imem_addr, 32'h20); chk("fr_v", {31'b0, id_valid}, 32'd0);
    redirect_target = 32'h103; step(1); redirect_valid = 0;
    chk("ff_fault", {31'b0, fetch_fault}, 32'd1); chk("ff_fpc", fault_pc, 32'h103);
    chk("ff_addr", imem_addr, 32'h20);
    rst = 1; step(1); rst = 0;

    // pc wrap via redirect to top of memory
    redirect_valid = 1; redirect_target = 32'hFFFF_FFFC; step(1); redirect_valid = 0;
    step(1); chk("wr_i", id_instr, 32'h00000003);
    id_ready = 1; step(1); id_ready = 0;
    chk("wr_addr", imem_addr, 32'h0); chk("wr_fault", {31'b0, fetch_fault}, 32'd0);

    // 6: RESET_VECTOR at top of memory
    chk("rv_addr", imem_addr2, 32'hFFFF_FFFC);
    rst2 = 0; id_ready2 = 1;
    step(1); chk("rv_pc", id_pc2, 32'hFFFF_FFFC); chk("rv_v", {31'b0, id_valid2}, 32'd1);
    step(1); chk("rv_wrap", imem_addr2, 32'h0); chk("rv_cnt", fetch_count2, 32'd1);
    chk("rv_fault", {31'b0, fetch_fault2}, 32'd0);
    step(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
